// File: rtl/reduce_stretch_if.sv
// Bus bundle for reduce_stretch: packed channel input, per-channel pulses and event count.
// REDUCE_MODE_EN adds the mode select used to pick OR/AND channel reduction.
interface reduce_stretch_if #(
  parameter int W  = 3,
  parameter int N  = 4,
  parameter int CW = 8
);
  logic           en;
`ifdef REDUCE_MODE_EN
  logic           mode;
`endif
  logic           clr;
  logic [N*W-1:0] d;
  logic [N-1:0]   q;
  logic           any;
  logic [CW-1:0]  evt_cnt;

  modport master (
    output en,
`ifdef REDUCE_MODE_EN
    output mode,
`endif
    output clr,
    output d,
    input  q,
    input  any,
    input  evt_cnt
  );

  modport slave (
    input  en,
`ifdef REDUCE_MODE_EN
    input  mode,
`endif
    input  clr,
    input  d,
    output q,
    output any,
    output evt_cnt
  );
endinterface

// File: rtl/reduce_stretch.sv
// Multi-channel reduce + pulse stretcher with a saturating new-event counter.
// Optional macro REDUCE_MODE_EN selects OR/AND reduction via the mode input.
module reduce_stretch #(
  parameter int W    = 3,
  parameter int N    = 4,
  parameter int HOLD = 3,
  parameter int CW   = 8
) (
  input logic            clk,
  input logic            rst,
  reduce_stretch_if.slave bus
);

  localparam int HW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int PW = $clog2(N + 1);
  localparam int SW = CW + PW;
  localparam logic [SW-1:0] MAX_CNT = {{PW{1'b0}}, {CW{1'b1}}};

  logic [N-1:0]  hit;
  logic [N-1:0]  new_evt;
  logic [N-1:0]  q_p1;
  logic [HW-1:0] cnt_p1 [N];
  logic [CW-1:0] evt_p1;

  function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // Widened add so a multi-channel burst near the top clamps instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] acc, input logic [PW-1:0] inc);
    logic [SW-1:0] sum;
    sum = {{PW{1'b0}}, acc} + {{CW{1'b0}}, inc};
    if (sum > MAX_CNT) return {CW{1'b1}};
    return sum[CW-1:0];
  endfunction

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
`ifdef REDUCE_MODE_EN
      hit[i] = bus.en & (bus.mode ? (&bus.d[i*W +: W]) : (|bus.d[i*W +: W]));
`else
      hit[i] = bus.en & (|bus.d[i*W +: W]);
`endif
    end
  end

  // Only the rising start of a stretched pulse is an event; retriggers are not.
  assign new_evt = hit & ~q_p1;

  // Stage p1: stretch state and event counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_p1[i] <= '0;
      q_p1   <= '0;
      evt_p1 <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.clr) begin
          cnt_p1[i] <= '0;
          q_p1[i]   <= 1'b0;
        end else if (hit[i]) begin
          cnt_p1[i] <= HW'(HOLD);
          q_p1[i]   <= 1'b1;
        end else if (cnt_p1[i] != '0) begin
          cnt_p1[i] <= cnt_p1[i] - HW'(1);
          q_p1[i]   <= 1'b1;
        end else begin
          q_p1[i]   <= 1'b0;
        end
      end
      if (bus.clr) evt_p1 <= '0;
      else         evt_p1 <= sat_add(evt_p1, popcount(new_evt));
    end
  end

  assign bus.q       = q_p1;
  assign bus.any     = |q_p1;
  assign bus.evt_cnt = evt_p1;

endmodule

// File: tb/tb_reduce_stretch.sv
// Directed bench for reduce_stretch: default instance (CW=8) plus a CW=3 instance for saturation.
module tb_reduce_stretch;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reduce_stretch_if #(.W(3), .N(4), .CW(8)) bus ();
  reduce_stretch_if #(.W(3), .N(4), .CW(3)) sbus ();

  reduce_stretch #(.W(3), .N(4), .HOLD(3), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  reduce_stretch #(.W(3), .N(4), .HOLD(3), .CW(3)) dut_s (.clk(clk), .rst(rst), .bus(sbus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b1; bus.clr = 1'b0; bus.d = 12'hFFF;
    sbus.en = 1'b1; sbus.clr = 1'b0; sbus.d = 12'h000;
`ifdef REDUCE_MODE_EN
    bus.mode = 1'b0; sbus.mode = 1'b0;
`endif
    // reset held with all hits active
    step(); step();
    chk("rst_q", 32'(bus.q), 32'h0);
    chk("rst_any", 32'(bus.any), 32'h0);
    chk("rst_evt", 32'(bus.evt_cnt), 32'h0);
    rst = 1'b0;
    step();
    chk("rel_q", 32'(bus.q), 32'hF);
    chk("rel_evt", 32'(bus.evt_cnt), 32'd4);
    bus.d = 12'h000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rel_hold", 32'(bus.q), 32'hF);
    end
    step();
    chk("rel_drop_q", 32'(bus.q), 32'h0);
    chk("rel_drop_any", 32'(bus.any), 32'h0);

    // single pulse on channel 1
    bus.d = 12'b000_000_010_000;
    step();
    chk("single_q0", 32'(bus.q), 32'h2);
    chk("single_evt", 32'(bus.evt_cnt), 32'd5);
    bus.d = 12'h000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("single_hold", 32'(bus.q), 32'h2);
    end
    step();
    chk("single_end", 32'(bus.q), 32'h0);

    // retrigger on channel 0
    bus.d = 12'h001;
    step();
    chk("retrig_a", 32'(bus.q), 32'h1);
    bus.d = 12'h000;
    step();
    chk("retrig_b", 32'(bus.q), 32'h1);
    bus.d = 12'h001;
    step();
    chk("retrig_c", 32'(bus.q), 32'h1);
    bus.d = 12'h000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("retrig_hold", 32'(bus.q), 32'h1);
    end
    step();
    chk("retrig_end", 32'(bus.q), 32'h0);
    chk("retrig_evt", 32'(bus.evt_cnt), 32'd6);

    // clear beats a simultaneous retrigger on channel 2
    bus.d = 12'h100;
    step();
    chk("clr_pre_q", 32'(bus.q), 32'h4);
    chk("clr_pre_evt", 32'(bus.evt_cnt), 32'd7);
    bus.clr = 1'b1;
    step();
    chk("clr_q", 32'(bus.q), 32'h0);
    chk("clr_evt", 32'(bus.evt_cnt), 32'h0);
    bus.clr = 1'b0; bus.d = 12'h000;
    step();
    chk("clr_after_q", 32'(bus.q), 32'h0);
    chk("clr_after_evt", 32'(bus.evt_cnt), 32'h0);

    // en=0 masks hits but not running stretches
    bus.en = 1'b0; bus.d = 12'hFFF;
    step();
    chk("en0_q", 32'(bus.q), 32'h0);
    chk("en0_evt", 32'(bus.evt_cnt), 32'h0);
    bus.en = 1'b1; bus.d = 12'b100_000_000_000;
    step();
    chk("en1_q", 32'(bus.q), 32'h8);
    chk("en1_evt", 32'(bus.evt_cnt), 32'd1);
    bus.en = 1'b0; bus.d = 12'hFFF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en0_hold", 32'(bus.q), 32'h8);
    end
    step();
    chk("en0_end", 32'(bus.q), 32'h0);
    chk("en0_end_evt", 32'(bus.evt_cnt), 32'd1);

    // asynchronous reset mid-pulse
    bus.en = 1'b1; bus.d = 12'h001;
    step();
    chk("arst_pre_q", 32'(bus.q), 32'h1);
    chk("arst_pre_evt", 32'(bus.evt_cnt), 32'd2);
    bus.d = 12'h000;
    #2 rst = 1'b1;
    #1;
    chk("arst_q", 32'(bus.q), 32'h0);
    chk("arst_evt", 32'(bus.evt_cnt), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("arst_no_residue", 32'(bus.q), 32'h0);

    // partial pattern 3'b011 on channel 0
`ifdef REDUCE_MODE_EN
    bus.mode = 1'b1; bus.d = 12'h003;
    step();
    chk("and_partial", 32'(bus.q), 32'h0);
    bus.d = 12'h007;
    step();
    chk("and_full", 32'(bus.q), 32'h1);
    bus.mode = 1'b0;
`else
    bus.d = 12'h003;
    step();
    chk("or_partial", 32'(bus.q), 32'h1);
`endif
    bus.d = 12'h000;

    // saturation on the CW=3 instance
    for (int r = 0; r < 3; r++) begin
      sbus.d = 12'hFFF;
      step();
      chk("sat_q", 32'(sbus.q), 32'hF);
      chk("sat_evt", 32'(sbus.evt_cnt), (r == 0) ? 32'd4 : 32'd7);
      sbus.d = 12'h000;
      for (int k = 0; k < 4; k++) step();
      chk("sat_idle_q", 32'(sbus.q), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reduce_stretch.md
Name: reduce_stretch

Overview:
- Parametrised multi-channel successor to the single-channel OR-reduce submodule.
- Splits a packed input bus into N channels of W bits and reduces each channel to a hit bit.
- Stretches each hit into a registered pulse held for HOLD extra cycles.
- Counts new events across all channels in a saturating counter.
- Sits after raw detector/status buses, ahead of slow-clocked or software-polled monitoring logic.

Parameters:
W, 3, bits per channel (>=1)
N, 4, number of channels (>=1)
HOLD, 3, extra cycles q stays high after the last hit (>=0)
CW, 8, event counter width (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  hit enable; en=0 masks all hits
clr  input  1  synchronous clear of stretch state and counter
d  input  N*W  packed channels; channel i = d[i*W+W-1 : i*W]
q  output  N  per-channel stretched pulse, registered
any  output  1  OR of q (combinational from registers)
evt_cnt  output  CW  saturating count of new events

Behaviour:
- Reset (rst=1, asynchronous): q=0, all per-channel hold counters=0, evt_cnt=0, so any=0. Release is synchronous to the next clk edge.
- hit[i] = en & (|d_i). Combinational, not registered.
- Per channel i, at each clk edge, first matching rule wins:
  - clr=1: cnt[i]<=0, q[i]<=0.
  - hit[i]=1: cnt[i]<=HOLD, q[i]<=1 (retrigger reloads HOLD).
  - cnt[i]!=0: cnt[i]<=cnt[i]-1, q[i]<=1.
  - else: q[i]<=0.
- Hold counter width: clog2(HOLD+1), minimum 1 bit.
- Latency d->q is 1 cycle.
- An isolated single-cycle hit gives q high for exactly HOLD+1 cycles. With HOLD=0, q follows the hit delayed by 1 cycle.
- Continuous hits keep q high; q falls HOLD+1 cycles after the last hit edge.
- New event on channel i: hit[i]=1 while q[i]=0, i.e. the start of a new stretched pulse. Retriggers while q[i]=1 do not count.
- evt_cnt: at each edge, add popcount(new events), 0..N per cycle.
  - Saturates at 2^CW-1; never wraps.
  - The addition uses CW+clog2(N+1) bits, then clamps.
- clr=1 forces evt_cnt<=0 and takes priority over simultaneous hits; hits in that cycle are lost.
- rst mid-pulse: everything returns to 0 immediately; no residual stretch after release.
- en=0: no new hits and no events. Active stretches keep counting down and finish normally.

Optional Feature:
- Macro REDUCE_MODE_EN.
- Defined:
  - Adds input port mode (1 bit), placed after en.
  - mode=0: channel reduction is OR.
  - mode=1: channel reduction is AND, hit[i]=en & (&d_i).
  - mode is sampled combinationally each cycle. Changing it mid-pulse does not affect stretches already running.
- Not defined: no mode port; reduction is always OR.

Test Plan:
- Reset: rst=1 with d all ones and en=1 -> q=0, any=0, evt_cnt=0 while reset is held. After release, first edge gives q=4'b1111 and evt_cnt=4.
- Single pulse: W=3, N=4, HOLD=3; d channel 1 =3'b010 for one cycle -> q=4'b0010 for exactly 4 cycles, then 0; evt_cnt increments by 1.
- Retrigger: hits on channel 0 at cycles 0 and 2 -> q[0] high cycles 1..6 continuously; evt_cnt increments by only 1.
- Saturation: CW=3; four channels hit, then idle until q drops, repeated twice -> evt_cnt goes 0->4->7 and stays 7.
- Clear priority: clr=1 in the same cycle as a hit on channel 2 while q[2]=1 -> next cycle q=0, evt_cnt=0. The hit is not counted.
- Mode (REDUCE_MODE_EN defined): mode=1, d channel 0=3'b011 -> no hit. d channel 0=3'b111 -> q[0]=1 next cycle. Without the macro, 3'b011 hits.
